seven_seg_scan_ctrl: RTL



---
 rtl/seg_display_pkg.sv | 18 +
 rtl/hex_to_seg7.sv | 11 +
 rtl/seven_seg_scan_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/seg_display_pkg.sv
// Shared constants for the 4-digit common-anode display: blanking patterns,
// the active-low hex glyph table and the digit-index type.
package seg_display_pkg;

   localparam logic [3:0] ANODE_OFF = 4'b1111;
   localparam logic [6:0] SEG_OFF   = 7'b1111111;

   typedef logic [1:0] digit_idx_t;

   // Segment order {g,f,e,d,c,b,a}, active-low; index is the hex value
   localparam logic [6:0] GLYPH [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex-digit to active-low 7-segment glyph decoder.
module hex_to_seg7
   import seg_display_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   assign seg = GLYPH[hex];

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// 4-digit 7-segment scan controller with tear-free frame swap and blanking guard.
// Define SEVEN_SEG_DP_EN to add per-digit decimal-point input/output.
module seven_seg_scan_ctrl
   import seg_display_pkg::*;
#(
   parameter int PRESCALE     = 50000,
   parameter int BLANK_CYCLES = 5000,
   parameter int CNT_W        = 16
)
(
   input  logic        Clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
`ifdef SEVEN_SEG_DP_EN
   input  logic [3:0]  in_dp,
   output logic        dp,
`endif
   output logic [3:0]  anode,
   output logic [6:0]  seg,
   output logic        frame_done
);

   logic [CNT_W-1:0] cnt;
   digit_idx_t       idx;
   logic [15:0]      disp;
   logic [15:0]      pend;
   logic             pend_full;
`ifdef SEVEN_SEG_DP_EN
   logic [3:0]       disp_dp;
   logic [3:0]       pend_dp;
`endif

   logic       wrap;
   logic       last_slot;
   logic       blank;
   logic       drive;
   logic       accept;
   logic [3:0] nibble;
   logic [6:0] glyph;

   assign wrap      = (cnt == CNT_W'(PRESCALE - 1));
   assign last_slot = wrap && (idx == 2'd3);
   assign in_ready  = !pend_full;
   assign accept    = in_valid && !pend_full;

   generate
      if (BLANK_CYCLES == 0) begin : g_no_blank
         assign blank = 1'b0;
      end else begin : g_blank
         assign blank = (cnt < CNT_W'(BLANK_CYCLES));
      end
   endgenerate

   // Outputs are forced off while reset is held, independent of the clock
   assign drive      = reset && !blank;
   assign frame_done = reset && last_slot;

   always_comb begin
      nibble = disp[15:12];
      case (idx)
         2'd0: nibble = disp[15:12];
         2'd1: nibble = disp[11:8];
         2'd2: nibble = disp[7:4];
         2'd3: nibble = disp[3:0];
         default: nibble = disp[15:12];
      endcase
   end

   hex_to_seg7 u_hex_to_seg7 (
      .hex (nibble),
      .seg (glyph)
   );

   assign seg = drive ? glyph : SEG_OFF;

   // digit0 is the leftmost digit and owns anode[3]
   for (genvar gi = 0; gi < 4; gi++) begin : g_anode
      assign anode[gi] = !(drive && (idx == digit_idx_t'(3 - gi)));
   end

`ifdef SEVEN_SEG_DP_EN
   assign dp = !(drive && disp_dp[~idx]);
`endif

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         cnt       <= '0;
         idx       <= '0;
         disp      <= 16'h0000;
         pend      <= 16'h0000;
         pend_full <= 1'b0;
`ifdef SEVEN_SEG_DP_EN
         disp_dp   <= 4'h0;
         pend_dp   <= 4'h0;
`endif
      end else begin
         cnt <= wrap ? '0 : cnt + 1'b1;
         if (wrap)
            idx <= idx + 1'b1;
         // Accept needs pend empty, swap needs pend full: never both at once
         if (accept) begin
            pend      <= in_data;
            pend_full <= 1'b1;
`ifdef SEVEN_SEG_DP_EN
            pend_dp   <= in_dp;
`endif
         end else if (last_slot && pend_full) begin
            disp      <= pend;
            pend_full <= 1'b0;
`ifdef SEVEN_SEG_DP_EN
            disp_dp   <= pend_dp;
`endif
         end
      end
   end

endmodule
